// File: rtl/mpc_operand_seq.sv
// Operand buffer and select sequencer for the MPC 4:1 operand mux: loads four words
// through a valid/ready port, then sweeps the mux select from a chosen start index.
module mpc_operand_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 2   // only 2 is supported: bank0..bank3 map one-to-one onto the entries
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [SEL_WIDTH-1:0]  start_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_vld,
  output logic                  wr_rdy,
  output logic [DATA_WIDTH-1:0] bank0,
  output logic [DATA_WIDTH-1:0] bank1,
  output logic [DATA_WIDTH-1:0] bank2,
  output logic [DATA_WIDTH-1:0] bank3,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  sel_vld,
  input  logic                  sel_rdy
);

  localparam int DEPTH = 1 << SEL_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic [SEL_WIDTH-1:0]  scnt_q, scnt_d;
  logic [SEL_WIDTH-1:0]  idx_q, idx_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] bank_q [DEPTH];
  logic [DATA_WIDTH-1:0] bank_d [DEPTH];

  logic wr_fire;
  logic sel_fire;

  assign wr_fire  = (state_q == S_LOAD) && wr_vld;
  assign sel_fire = (state_q == S_SWEEP) && sel_rdy;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    bank_d  = bank_q;

    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          idx_d   = start_idx;
          wcnt_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (wr_fire) begin
          bank_d[wcnt_q] = wr_data;
          wcnt_d         = wcnt_q + SEL_WIDTH'(1);
          if (wcnt_q == '1) begin
            scnt_d  = '0;
            sel_d   = idx_q;
            state_d = S_SWEEP;
          end
        end
      end
      S_SWEEP: begin
        // On the last accept sel is left alone so it keeps the final select through DONE.
        if (sel_fire) begin
          if (scnt_q == '1) begin
            state_d = S_DONE;
          end else begin
            scnt_d = scnt_q + SEL_WIDTH'(1);
            sel_d  = sel_q + SEL_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      // NOTE: the word store is reset too, so an aborted load leaves no stale words visible
      // on bank0..bank3; it is only four registers, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge _d values.
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      bank_q  <= bank_d;
    end
  end

  // Handshake flags decode the state directly; ap_ready fires in the cycle of the 4th accept.
  assign ap_idle  = (state_q == S_IDLE);
  assign ap_done  = (state_q == S_DONE);
  assign wr_rdy   = (state_q == S_LOAD);
  assign sel_vld  = (state_q == S_SWEEP);
  assign ap_ready = wr_fire && (wcnt_q == '1);

  assign sel   = sel_q;
  assign bank0 = bank_q[0];
  assign bank1 = bank_q[1];
  assign bank2 = bank_q[2];
  assign bank3 = bank_q[3];

endmodule

// File: tb/tb_mpc_operand_seq.sv
// Directed bench for mpc_operand_seq: a cycle table for the nominal load/sweep, then
// hand-written sequences for wrap, stall, write gaps, mid-sweep reset and held ap_start.
module tb_mpc_operand_seq;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [1:0]  start_idx;
  logic [31:0] wr_data;
  logic        wr_vld;
  logic        wr_rdy;
  logic [31:0] bank0, bank1, bank2, bank3;
  logic [1:0]  sel;
  logic        sel_vld;
  logic        sel_rdy;
  logic [31:0] mux_out;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  mpc_operand_seq #(.DATA_WIDTH(32), .SEL_WIDTH(2)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ap_start  (ap_start),
    .ap_done   (ap_done),
    .ap_idle   (ap_idle),
    .ap_ready  (ap_ready),
    .start_idx (start_idx),
    .wr_data   (wr_data),
    .wr_vld    (wr_vld),
    .wr_rdy    (wr_rdy),
    .bank0     (bank0),
    .bank1     (bank1),
    .bank2     (bank2),
    .bank3     (bank3),
    .sel       (sel),
    .sel_vld   (sel_vld),
    .sel_rdy   (sel_rdy)
  );

  // Downstream 4:1 operand mux as wired in the datapath.
  always_comb begin
    mux_out = bank0;
    case (sel)
      2'd0: mux_out = bank0;
      2'd1: mux_out = bank1;
      2'd2: mux_out = bank2;
      2'd3: mux_out = bank3;
      default: mux_out = bank0;
    endcase
  end

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  always @(negedge ap_clk) begin
    if (ap_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          start;
    logic [1:0]  idx;
    logic [31:0] wdata;
    bit          wvld;
    bit          srdy;
    bit          e_idle;
    bit          e_ready;
    bit          e_done;
    bit          e_wrdy;
    bit          e_svld;
    logic [1:0]  e_sel;
    logic [31:0] e_mux;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Starts an operation from IDLE and feeds four words; gaps inserts an invalid beat
  // after each valid one, hold keeps ap_start high and scrambles start_idx during LOAD.
  task automatic do_load(input logic [1:0] idx, input logic [3:0][31:0] w,
                         input bit gaps, input bit hold);
    start_idx = idx;
    ap_start  = 1'b1;
    wr_vld    = 1'b0;
    @(negedge ap_clk);
    check("load_entry_idle", 32'(ap_idle), 32'd1);
    check("load_entry_done", 32'(ap_done), 32'd0);
    tick();
    if (hold) start_idx = ~idx;
    else      ap_start  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_vld  = 1'b1;
      wr_data = w[i];
      @(negedge ap_clk);
      check("load_wr_rdy", 32'(wr_rdy), 32'd1);
      check("load_idle", 32'(ap_idle), 32'd0);
      check("load_ap_ready", 32'(ap_ready), (i == 3) ? 32'd1 : 32'd0);
      tick();
      if (gaps && i < 3) begin
        wr_vld  = 1'b0;
        wr_data = 32'hDEAD_0000 | 32'(i);
        @(negedge ap_clk);
        check("gap_wr_rdy", 32'(wr_rdy), 32'd1);
        check("gap_ap_ready", 32'(ap_ready), 32'd0);
        tick();
      end
    end
  endtask

  // Runs the sweep with wr_vld forced high on junk data; optionally stalls sel_rdy at
  // select number stall_at for stall_len cycles. Returns one cycle into IDLE.
  task automatic do_sweep(input logic [1:0] idx, input logic [3:0][31:0] w,
                          input int stall_at, input int stall_len);
    logic [1:0] s;
    wr_vld  = 1'b1;
    wr_data = 32'hBAD0_BAD0;
    sel_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s = idx + 2'(k);
      if (k == stall_at) begin
        sel_rdy = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          @(negedge ap_clk);
          check("stall_sel_vld", 32'(sel_vld), 32'd1);
          check("stall_sel", 32'(sel), 32'(s));
          check("stall_mux", mux_out, w[s]);
          check("stall_done", 32'(ap_done), 32'd0);
          tick();
        end
        sel_rdy = 1'b1;
      end
      @(negedge ap_clk);
      check("sweep_sel_vld", 32'(sel_vld), 32'd1);
      check("sweep_sel", 32'(sel), 32'(s));
      check("sweep_mux", mux_out, w[s]);
      check("sweep_wr_rdy", 32'(wr_rdy), 32'd0);
      check("sweep_done", 32'(ap_done), 32'd0);
      tick();
    end
    s = idx + 2'd3;
    @(negedge ap_clk);
    check("done_pulse", 32'(ap_done), 32'd1);
    check("done_sel_vld", 32'(sel_vld), 32'd0);
    check("done_idle", 32'(ap_idle), 32'd0);
    check("done_sel_hold", 32'(sel), 32'(s));
    check("bank0", bank0, w[0]);
    check("bank1", bank1, w[1]);
    check("bank2", bank2, w[2]);
    check("bank3", bank3, w[3]);
    tick();
    wr_vld = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"}, 32'(ap_idle), 32'd1);
    check({tag, "_done"}, 32'(ap_done), 32'd0);
    check({tag, "_ready"}, 32'(ap_ready), 32'd0);
    check({tag, "_wr_rdy"}, 32'(wr_rdy), 32'd0);
    check({tag, "_sel_vld"}, 32'(sel_vld), 32'd0);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_bank0"}, bank0, 32'd0);
    check({tag, "_bank1"}, bank1, 32'd0);
    check({tag, "_bank2"}, bank2, 32'd0);
    check({tag, "_bank3"}, bank3, 32'd0);
  endtask

  initial begin
    logic [3:0][31:0] wa;
    logic [3:0][31:0] wb;
    logic [3:0][31:0] wc;
    int d0;

    // start, idx, wdata, wvld, srdy | idle, ready, done, wr_rdy, sel_vld, sel, mux
    vecs[0]  = '{1, 2'd0, 32'h11, 1, 1, 1, 0, 0, 0, 0, 2'd0, 32'h00};
    vecs[1]  = '{0, 2'd0, 32'h11, 1, 1, 0, 0, 0, 1, 0, 2'd0, 32'h00};
    vecs[2]  = '{0, 2'd0, 32'h22, 1, 1, 0, 0, 0, 1, 0, 2'd0, 32'h11};
    vecs[3]  = '{0, 2'd0, 32'h33, 1, 1, 0, 0, 0, 1, 0, 2'd0, 32'h11};
    vecs[4]  = '{0, 2'd0, 32'h44, 1, 1, 0, 1, 0, 1, 0, 2'd0, 32'h11};
    vecs[5]  = '{0, 2'd0, 32'h55, 1, 1, 0, 0, 0, 0, 1, 2'd0, 32'h11};
    vecs[6]  = '{0, 2'd0, 32'h55, 1, 1, 0, 0, 0, 0, 1, 2'd1, 32'h22};
    vecs[7]  = '{0, 2'd0, 32'h55, 1, 1, 0, 0, 0, 0, 1, 2'd2, 32'h33};
    vecs[8]  = '{0, 2'd0, 32'h55, 1, 1, 0, 0, 0, 0, 1, 2'd3, 32'h44};
    vecs[9]  = '{0, 2'd0, 32'h55, 0, 1, 0, 0, 1, 0, 0, 2'd3, 32'h44};
    vecs[10] = '{0, 2'd0, 32'h55, 0, 1, 1, 0, 0, 0, 0, 2'd3, 32'h44};

    wa = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    wb = {32'hB000_0004, 32'hB000_0003, 32'hB000_0002, 32'hB000_0001};
    wc = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

    ap_rst_n  = 1'b0;
    ap_start  = 1'b0;
    start_idx = 2'd0;
    wr_data   = 32'd0;
    wr_vld    = 1'b0;
    sel_rdy   = 1'b0;
    #2;
    check_reset_outputs("por");
    #10;
    ap_rst_n = 1'b1;
    tick();

    // Nominal load/sweep with the cycle-exact latency table.
    for (int i = 0; i < 11; i++) begin
      ap_start  = vecs[i].start;
      start_idx = vecs[i].idx;
      wr_data   = vecs[i].wdata;
      wr_vld    = vecs[i].wvld;
      sel_rdy   = vecs[i].srdy;
      @(negedge ap_clk);
      check($sformatf("c%0d_idle", i), 32'(ap_idle), 32'(vecs[i].e_idle));
      check($sformatf("c%0d_ready", i), 32'(ap_ready), 32'(vecs[i].e_ready));
      check($sformatf("c%0d_done", i), 32'(ap_done), 32'(vecs[i].e_done));
      check($sformatf("c%0d_wr_rdy", i), 32'(wr_rdy), 32'(vecs[i].e_wrdy));
      check($sformatf("c%0d_sel_vld", i), 32'(sel_vld), 32'(vecs[i].e_svld));
      check($sformatf("c%0d_sel", i), 32'(sel), 32'(vecs[i].e_sel));
      check($sformatf("c%0d_mux", i), mux_out, vecs[i].e_mux);
      tick();
    end

    // Wrapping sweep from index 3, exactly one ap_done.
    d0 = done_cnt;
    do_load(2'd3, wa, 1'b0, 1'b0);
    do_sweep(2'd3, wa, -1, 0);
    @(negedge ap_clk);
    check("wrap_after_idle", 32'(ap_idle), 32'd1);
    check("wrap_after_done", 32'(ap_done), 32'd0);
    tick();
    tick();
    check("wrap_done_count", 32'(done_cnt - d0), 32'd1);

    // sel_rdy stalled for 3 cycles on the second select.
    do_load(2'd0, wb, 1'b0, 1'b0);
    do_sweep(2'd0, wb, 1, 3);

    // Alternating wr_vld during LOAD; wr_vld during SWEEP ignored.
    do_load(2'd1, wc, 1'b1, 1'b0);
    do_sweep(2'd1, wc, -1, 0);

    // Asynchronous reset in mid-sweep, after sel=1 has been accepted.
    do_load(2'd0, wa, 1'b0, 1'b0);
    sel_rdy = 1'b1;
    tick();
    tick();
    @(negedge ap_clk);
    check("pre_reset_sel", 32'(sel), 32'd2);
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #2;
    ap_rst_n = 1'b1;
    tick();
    do_load(2'd2, wb, 1'b0, 1'b0);
    do_sweep(2'd2, wb, -1, 0);

    // ap_start held high: back-to-back operations with one IDLE cycle between them.
    d0 = done_cnt;
    do_load(2'd1, wa, 1'b0, 1'b1);
    do_sweep(2'd1, wa, -1, 0);
    do_load(2'd2, wc, 1'b0, 1'b1);
    do_sweep(2'd2, wc, -1, 0);
    ap_start = 1'b0;
    @(negedge ap_clk);
    check("hold_final_idle", 32'(ap_idle), 32'd1);
    check("hold_done_count", 32'(done_cnt - d0), 32'd2);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
